// File: rtl/snow64_instr_cache.sv
// Direct-mapped read-only instruction cache with single-outstanding line fill.
// Optional hit/miss counters are enabled by defining SNOW64_INSTR_CACHE_PERF_COUNTERS_EN.
module snow64_instr_cache #(
  parameter int NUM_LINES   = 32,
  parameter int WIDTH__LINE = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_req,
  input  logic [63:0]            in_addr,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic                   out_mem_req,
  output logic [63:0]            out_mem_addr,
  input  logic                   in_mem_valid,
  input  logic [WIDTH__LINE-1:0] in_mem_data
`ifdef SNOW64_INSTR_CACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]            out_hit_count,
  output logic [31:0]            out_miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 59 - IDX_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MISS_WAIT = 2'd1;
  localparam logic [1:0] ST_RESPOND   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_instr_q, out_instr_d;
  logic                   mem_req_q, mem_req_d;
  logic [63:0]            mem_addr_q, mem_addr_d;
  logic [2:0]             word_q, word_d;

  logic [WIDTH__LINE-1:0] data_q [NUM_LINES];
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];

  logic [IDX_W-1:0]       req_idx_s;
  logic [TAG_W-1:0]       req_tag_s;
  logic [2:0]             req_word_s;
  logic [IDX_W-1:0]       fill_idx_s;
  logic [TAG_W-1:0]       fill_tag_s;
  logic                   hit_s;
  logic                   accept_s;
  logic                   fill_s;
  logic                   unused_s;

  assign req_idx_s  = in_addr[5 +: IDX_W];
  assign req_tag_s  = in_addr[63 -: TAG_W];
  assign req_word_s = in_addr[4:2];
  assign fill_idx_s = mem_addr_q[5 +: IDX_W];
  assign fill_tag_s = mem_addr_q[63 -: TAG_W];
  assign hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  // The respond cycle already accepts the next fetch so a fresh line is hittable right away.
  assign accept_s   = in_req && ((state_q == ST_IDLE) || (state_q == ST_RESPOND));
  assign fill_s     = (state_q == ST_MISS_WAIT) && in_mem_valid;
  assign unused_s   = ^in_addr[1:0];

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_instr_d = out_instr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    word_d      = word_q;
    case (state_q)
      ST_IDLE, ST_RESPOND: begin
        if (accept_s) begin
          if (hit_s) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            out_instr_d = data_q[req_idx_s][{req_word_s, 5'd0} +: 32];
          end else begin
            state_d    = ST_MISS_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = {in_addr[63:5], 5'd0};
            word_d     = req_word_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MISS_WAIT: begin
        if (in_mem_valid) begin
          state_d     = ST_RESPOND;
          out_valid_d = 1'b1;
          out_instr_d = in_mem_data[{word_q, 5'd0} +: 32];
          mem_req_d   = 1'b0;
        end else begin
          state_d = ST_MISS_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Valid-bit update on fill completion.
  always_comb begin
    valid_d = valid_q;
    if (fill_s) begin
      valid_d[fill_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Control state and outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= {NUM_LINES{1'b0}};
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 64'd0;
      word_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      word_q      <= word_d;
    end
  end

  // Line storage; contents need no reset because the valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (rst_n && fill_s) begin
      data_q[fill_idx_s] <= in_mem_data;
      tag_q[fill_idx_s]  <= fill_tag_s;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_mem_req  = mem_req_q;
  assign out_mem_addr = mem_addr_q;

`ifdef SNOW64_INSTR_CACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Counter increments per accepted request.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (accept_s && hit_s) begin
      hit_count_d = hit_count_q + 32'd1;
    end else if (accept_s) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign out_hit_count  = hit_count_q;
  assign out_miss_count = miss_count_q;
`endif

endmodule
